// File: rtl/mips_exec_ctrl.sv
// Execution controller for the MIPS debug system: decodes UART command bytes to
// load instruction memory, run to halt or single-step, then triggers a bucket dump.
module mips_exec_ctrl #(
   parameter int len_data      = 32,
   parameter int len_addr      = 7,
   parameter int NBIT_DATA_LEN = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [NBIT_DATA_LEN-1:0] rx_data_i,
   input  logic                     rx_done_tick_i,
   input  logic                     halt_i,
   input  logic                     dump_done_i,
   output logic                     mips_clk_en_o,
   output logic                     debug_o,
   output logic [len_addr-1:0]      inst_addr_o,
   output logic [len_data-1:0]      inst_data_o,
   output logic                     inst_we_o,
   output logic                     dump_start_o,
   output logic [31:0]              cycle_count_o,
   output logic [2:0]               state_out_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LD_CNT    = 3'd1,
      S_LD_WORD   = 3'd2,
      S_RUN       = 3'd3,
      S_STEP_WAIT = 3'd4,
      S_STEP      = 3'd5,
      S_DUMP      = 3'd6
   } state_e;

   localparam logic [NBIT_DATA_LEN-1:0] CMD_L = NBIT_DATA_LEN'(8'h4C);
   localparam logic [NBIT_DATA_LEN-1:0] CMD_R = NBIT_DATA_LEN'(8'h52);
   localparam logic [NBIT_DATA_LEN-1:0] CMD_S = NBIT_DATA_LEN'(8'h53);
   localparam logic [NBIT_DATA_LEN-1:0] CMD_N = NBIT_DATA_LEN'(8'h4E);
   localparam logic [NBIT_DATA_LEN-1:0] CMD_E = NBIT_DATA_LEN'(8'h45);
   localparam logic [1:0]               LAST_BYTE = 2'(len_data / NBIT_DATA_LEN - 1);

   state_e                   state_q, ret_q;
   logic                     debug_q, we_q, dstart_q;
   logic [len_addr-1:0]      addr_q;
   logic [len_data-1:0]      data_q;
   logic [31:0]              cnt_q;
   logic [NBIT_DATA_LEN-1:0] nwords_q, widx_q;
   logic [1:0]               bidx_q;
   logic                     clk_en;
   logic                     last_strobe;

   // Combinational so the MIPS never gets an edge in the cycle halt rises.
   assign clk_en      = ((state_q == S_RUN) && !halt_i) || (state_q == S_STEP);
   assign last_strobe = we_q && (widx_q == nwords_q - 1'b1);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q  <= S_IDLE;
         ret_q    <= S_IDLE;
         debug_q  <= 1'b0;
         we_q     <= 1'b0;
         dstart_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         cnt_q    <= '0;
         nwords_q <= '0;
         widx_q   <= '0;
         bidx_q   <= '0;
      end else begin
         we_q     <= 1'b0;
         dstart_q <= 1'b0;
         if (clk_en) cnt_q <= cnt_q + 32'd1;
         case (state_q)
            S_IDLE: begin
               if (rx_done_tick_i) begin
                  if (rx_data_i == CMD_L) begin
                     state_q <= S_LD_CNT;
                     cnt_q   <= '0;
                  end else if (rx_data_i == CMD_R) begin
                     if (halt_i) begin
                        state_q  <= S_DUMP;
                        ret_q    <= S_IDLE;
                        dstart_q <= 1'b1;
                     end else begin
                        state_q <= S_RUN;
                     end
                  end else if (rx_data_i == CMD_S) begin
                     state_q <= S_STEP_WAIT;
                     debug_q <= 1'b1;
                  end
               end
            end
            S_LD_CNT: begin
               if (rx_done_tick_i) begin
                  if (rx_data_i == '0) begin
                     state_q <= S_IDLE;
                  end else begin
                     nwords_q <= rx_data_i;
                     widx_q   <= '0;
                     addr_q   <= '0;
                     bidx_q   <= '0;
                     state_q  <= S_LD_WORD;
                  end
               end
            end
            S_LD_WORD: begin
               // Address advances at the end of the strobe cycle, keeping it stable during it.
               if (we_q) begin
                  addr_q <= addr_q + 1'b1;
                  widx_q <= widx_q + 1'b1;
                  if (last_strobe) state_q <= S_IDLE;
               end
               if (rx_done_tick_i && !last_strobe) begin
                  data_q <= {data_q[len_data-NBIT_DATA_LEN-1:0], rx_data_i};
                  bidx_q <= bidx_q + 1'b1;
                  if (bidx_q == LAST_BYTE) we_q <= 1'b1;
               end
            end
            S_RUN: begin
               if (halt_i) begin
                  state_q  <= S_DUMP;
                  ret_q    <= S_IDLE;
                  dstart_q <= 1'b1;
               end
            end
            S_STEP_WAIT: begin
               if (rx_done_tick_i) begin
                  if (rx_data_i == CMD_N) begin
                     if (halt_i) begin
                        state_q  <= S_DUMP;
                        ret_q    <= S_STEP_WAIT;
                        dstart_q <= 1'b1;
                     end else begin
                        state_q <= S_STEP;
                     end
                  end else if (rx_data_i == CMD_R) begin
                     debug_q <= 1'b0;
                     if (halt_i) begin
                        state_q  <= S_DUMP;
                        ret_q    <= S_IDLE;
                        dstart_q <= 1'b1;
                     end else begin
                        state_q <= S_RUN;
                     end
                  end else if (rx_data_i == CMD_E) begin
                     debug_q <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_STEP: begin
               state_q  <= S_DUMP;
               ret_q    <= S_STEP_WAIT;
               dstart_q <= 1'b1;
            end
            S_DUMP: begin
               if (dump_done_i) state_q <= ret_q;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mips_clk_en_o = clk_en;
   assign debug_o       = debug_q;
   assign inst_addr_o   = addr_q;
   assign inst_data_o   = data_q;
   assign inst_we_o     = we_q;
   assign dump_start_o  = dstart_q;
   assign cycle_count_o = cnt_q;
   assign state_out_o   = state_q;

endmodule

// File: doc/mips_exec_ctrl.md
# mips_exec_ctrl

Command-driven execution controller for the MIPS debug system. It decodes command bytes received from the UART and acts on them in one of three ways: loading instruction memory, running the MIPS to halt, or single-stepping it. It gates the MIPS clock and counts executed cycles. After each run or step it triggers the bucket dump over UART and waits for the dump to finish. It sits between the UART receiver, the MIPS core (clock enable, instruction-memory write port, halt) and the bucket serializer.

## Interface
- `len_data`, 32, instruction word width; must be 32.
- `len_addr`, 7, instruction-memory address width.
- `NBIT_DATA_LEN`, 8, UART byte width.

Ports:
- `clk`  in  1  system clock; all logic rises on it.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  NBIT_DATA_LEN  received UART byte; valid when `rx_done_tick`=1.
- `rx_done_tick`  in  1  one-cycle pulse per received byte.
- `halt`  in  1  MIPS halt flag; level, sticky until MIPS reset.
- `dump_done`  in  1  one-cycle pulse when the bucket serializer has finished sending.
- `mips_clk_en`  out  1  MIPS clock enable; drives the MIPS clock gate.
- `debug`  out  1  high while in step mode.
- `inst_addr`  out  len_addr  instruction-memory write address.
- `inst_data`  out  len_data  instruction-memory write data.
- `inst_we`  out  1  instruction-memory write strobe, one cycle per word.
- `dump_start`  out  1  one-cycle pulse that starts the bucket dump.
- `cycle_count`  out  32  number of enabled MIPS cycles since the last load.
- `state_out`  out  3  current state encoding, for LEDs.

## Operation

**States:** IDLE=0, LD_CNT=1, LD_WORD=2, RUN=3, STEP_WAIT=4, STEP=5, DUMP=6.

**Reset.** All outputs are 0, state is IDLE, `inst_addr`=0, `inst_data`=0, `cycle_count`=0.

**IDLE.** Only bytes with `rx_done_tick`=1 are decoded. All other bytes are ignored.
- 0x4C 'L' → LD_CNT; `cycle_count`←0.
- 0x52 'R' → RUN.
- 0x53 'S' → STEP_WAIT; `debug`←1.

**LD_CNT.** The next byte is the word count N.
- N=0 → IDLE.
- Otherwise store N, set word index 0, byte index 0, → LD_WORD.

**LD_WORD.** Each byte is shifted in MSB first: `inst_data`←{`inst_data`[23:0], rx_data}.
- On the 4th byte of a word, `inst_we`=1 for the next cycle, with `inst_addr` equal to the word index.
- The word index increments after the strobe. The address wraps modulo 2^len_addr.
- After the Nth word's strobe → IDLE.
- There is no timeout and bytes are never discarded; only reset aborts a load.

**RUN.**
- `mips_clk_en` = (state==RUN) & ~halt, combinational, so no cycle is enabled after `halt` rises.
- When `halt`=1 → DUMP, with return state IDLE.
- If `halt` is already 1 on entry, no cycle is enabled and the block goes straight to DUMP.

**STEP_WAIT.** `debug`=1 throughout.
- 0x4E 'N' → STEP, if `halt`=0. If `halt`=1 → DUMP with return state STEP_WAIT, and no cycle is enabled.
- 'R' → RUN; `debug`←0.
- 0x45 'E' → IDLE; `debug`←0.
- All other bytes are ignored.

**STEP.** Lasts exactly one cycle with `mips_clk_en`=1, then → DUMP with return state STEP_WAIT.

**DUMP.**
- `dump_start` pulses in the first DUMP cycle only.
- The block holds until `dump_done`, then goes to the return state.
- Bytes received in RUN, STEP or DUMP are dropped, including one that coincides with `dump_done`.

**Cycle counter.** `cycle_count` increments by 1 in every cycle where `mips_clk_en`=1. It wraps modulo 2^32 and clears only on 'L' or reset.

## Timing
- Command decode: a byte at edge k produces the state change at edge k+1.
- RUN begins enabling the MIPS in the cycle after 'R' is decoded.
- Load latency: the 4th byte is captured at edge k; `inst_we`=1 during cycle k+1 with stable addr and data.
- Step: 'N' is captured at edge k; `mips_clk_en`=1 for cycle k+1 only; `dump_start`=1 in cycle k+2.
- Halt: `halt` rises in cycle h; `mips_clk_en`=0 in cycle h; `dump_start`=1 in cycle h+1.
- `dump_done` in cycle d: the new state applies from cycle d+1.
- Reset asserted mid-load, run or dump: everything returns to the reset values immediately. A partial word is never written.

## Test plan
- **Load:** bytes 'L', 0x02, 0x11 0x22 0x33 0x44, 0xAA 0xBB 0xCC 0xDD → exactly two `inst_we` pulses: addr 0 / 0x11223344, then addr 1 / 0xAABBCCDD. Then state IDLE and `cycle_count`=0.
- **Run:** send 'R', then raise `halt` after 10 enabled cycles → `mips_clk_en` high for exactly 10 cycles, `cycle_count`=10, one `dump_start` pulse. After `dump_done` → IDLE.
- **Step mode:** 'S', then 'N' three times, each followed by `dump_done` → `debug`=1 throughout, three single-cycle enables, three `dump_start` pulses, `cycle_count`=3. Then 'E' → `debug`=0, IDLE.
- **Halt before start:** `halt`=1, then 'R' → zero enabled cycles and an immediate `dump_start`. In step mode with `halt`=1, 'N' → `dump_start` with no enable.
- **Edge cases:**
  - 'L', 0x00 → IDLE with no `inst_we`.
  - 'R' received during DUMP → ignored.
  - Reset asserted after 2 of 4 bytes → no `inst_we`, all outputs 0.
  - A 129-word load with `len_addr`=7 → word 128 is written to addr 0.
